// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: reset PC, NOP encoding, fetch FSM states and
// the layout of the ID/EX control bundle.
package cpu_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   localparam int unsigned CTRL_W       = 9;
   // Control bundle: EX [3:0], MEM [6:4], WB [8:7]
   localparam int unsigned CTRL_EX_LSB  = 0;
   localparam int unsigned CTRL_EX_W    = 4;
   localparam int unsigned CTRL_MEM_LSB = 4;
   localparam int unsigned CTRL_MEM_W   = 3;
   localparam int unsigned CTRL_WB_LSB  = 7;
   localparam int unsigned CTRL_WB_W    = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// PC, IF/ID and ID/EX-control registers driven by the hazard unit's stall
// signals and ID-stage branch redirects, with stall/flush statistics.
module fetch_stall_ctrl #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       CTRL_W    = cpu_pipe_pkg::CTRL_W,
   parameter logic [DATA_W-1:0] RESET_PC  = cpu_pipe_pkg::RESET_PC,
   parameter int unsigned       MAX_STALL = 2,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              hazard_mux,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [DATA_W-1:0] imem_instr,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [DATA_W-1:0] ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic              proto_err,
   output logic              stall_timeout
);

   import cpu_pipe_pkg::*;

   localparam int unsigned      RUN_W     = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

   logic              stall, flush;
   logic [DATA_W-1:0] pc_plus4;

   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   state_e            state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              timeout_q, timeout_d;
   logic              proto_q, proto_d;

   // A stalled branch has stale operands, so it is dropped until re-evaluated.
   assign stall    = ~pc_write;
   assign flush    = branch_taken & ~stall;
   assign pc_plus4 = pc_q + DATA_W'(4);

   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      state_d      = ST_RUN;
      run_d        = '0;
      timeout_d    = timeout_q;

      if (!stall) begin
         pc_d = branch_taken ? branch_target : pc_plus4;
      end

      if (ifid_write) begin
         if (branch_taken) begin
            ifid_instr_d = DATA_W'(NOP_INSTR);
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
         end else begin
            ifid_instr_d = imem_instr;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
         end
      end

      idex_ctrl_d = (hazard_mux || !ifid_valid_q) ? '0 : id_ctrl;

      if (stall) begin
         state_d = ST_STALL;
      end else if (flush) begin
         state_d = ST_FLUSH;
      end

      // Counts consecutive stalls; holds at the limit once the timeout is flagged.
      if (stall) begin
         run_d = (run_q == RUN_LIMIT) ? run_q : run_q + RUN_W'(1);
         if (run_q >= RUN_LIMIT) begin
            timeout_d = 1'b1;
         end
      end

      proto_d = proto_q | (pc_write != ifid_write) | (hazard_mux == pc_write);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= DATA_W'(NOP_INSTR);
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
         idex_ctrl_q  <= '0;
         state_q      <= ST_RUN;
         run_q        <= '0;
         timeout_q    <= 1'b0;
         proto_q      <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         idex_ctrl_q  <= idex_ctrl_d;
         state_q      <= state_d;
         run_q        <= run_d;
         timeout_q    <= timeout_d;
         proto_q      <= proto_d;
      end
   end

   sat_counter #(
      .WIDTH(CNT_W)
   ) u_stall_cnt (
      .clk_i(clk),
      .clr_i(rst),
      .en_i (stall),
      .cnt_o(stall_cnt)
   );

   sat_counter #(
      .WIDTH(CNT_W)
   ) u_flush_cnt (
      .clk_i(clk),
      .clr_i(rst),
      .en_i (flush),
      .cnt_o(flush_cnt)
   );

   assign pc            = pc_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc4      = ifid_pc4_q;
   assign ifid_valid    = ifid_valid_q;
   assign idex_ctrl     = idex_ctrl_q;
   assign state         = state_q;
   assign proto_err     = proto_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench: driver updates a behavioural model and queues the expected
// register snapshot; a negedge monitor pops and compares every cycle.
module tb_fetch_stall_ctrl;

   localparam int MAX_STALL = 2;
   localparam int CNT_MAX   = 65535;

   logic        clk = 1'b0;
   logic        rst, pc_write, ifid_write, hazard_mux, branch_taken;
   logic [31:0] branch_target, imem_instr;
   logic [8:0]  id_ctrl;
   logic [31:0] pc, ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [8:0]  idex_ctrl;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;
   logic        proto_err, stall_timeout;

   always #5 clk = ~clk;

   fetch_stall_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .hazard_mux   (hazard_mux),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_instr   (imem_instr),
      .id_ctrl      (id_ctrl),
      .pc           (pc),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .idex_ctrl    (idex_ctrl),
      .state        (state),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .proto_err    (proto_err),
      .stall_timeout(stall_timeout)
   );

   typedef struct {
      logic [31:0] pc, instr, pc4;
      logic        valid;
      logic [8:0]  ctrl;
      logic [1:0]  st;
      int          scnt, fcnt;
      logic        perr, tmo;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_perr, m_tmo;
   logic [8:0]  m_ctrl;
   logic [1:0]  m_st;
   int          m_scnt, m_fcnt, m_run;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc", pc, e.pc);
         chk("ifid_instr", ifid_instr, e.instr);
         chk("ifid_pc4", ifid_pc4, e.pc4);
         chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
         chk("idex_ctrl", 32'(idex_ctrl), 32'(e.ctrl));
         chk("state", 32'(state), 32'(e.st));
         chk("stall_cnt", 32'(stall_cnt), e.scnt);
         chk("flush_cnt", 32'(flush_cnt), e.fcnt);
         chk("proto_err", 32'(proto_err), 32'(e.perr));
         chk("stall_timeout", 32'(stall_timeout), 32'(e.tmo));
      end
   end

   task automatic model(input bit r, pcw, ifw, hm, bt, input logic [31:0] tgt, ins,
                        input logic [8:0] ctl);
      bit stl;
      logic [31:0] nxt;
      if (r) begin
         m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_ctrl = 0; m_st = 2'd0;
         m_scnt = 0; m_fcnt = 0; m_run = 0; m_perr = 0; m_tmo = 0;
         return;
      end
      stl = !pcw;
      nxt = m_pc + 32'd4;
      m_ctrl = (hm || !m_valid) ? 9'd0 : ctl;
      if (ifw) begin
         if (bt) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
         end else begin
            m_instr = ins; m_pc4 = nxt; m_valid = 1;
         end
      end
      if (!stl) m_pc = bt ? tgt : nxt;
      m_st = stl ? 2'd1 : (bt ? 2'd2 : 2'd0);
      if (stl && m_scnt < CNT_MAX) m_scnt++;
      if (!stl && bt && m_fcnt < CNT_MAX) m_fcnt++;
      m_run = stl ? m_run + 1 : 0;
      if (m_run > MAX_STALL) m_tmo = 1;
      if ((pcw != ifw) || (hm == pcw)) m_perr = 1;
   endtask

   task automatic step(input bit r, pcw, ifw, hm, bt, input logic [31:0] tgt, ins,
                       input logic [8:0] ctl, input bit check = 1'b1);
      exp_t e;
      rst = r; pc_write = pcw; ifid_write = ifw; hazard_mux = hm;
      branch_taken = bt; branch_target = tgt; imem_instr = ins; id_ctrl = ctl;
      model(r, pcw, ifw, hm, bt, tgt, ins, ctl);
      e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, ctrl: m_ctrl, st: m_st,
            scnt: m_scnt, fcnt: m_fcnt, perr: m_perr, tmo: m_tmo};
      @(posedge clk);
      if (check) exp_q.push_back(e);
      #1;
   endtask

   localparam logic [31:0] LW = 32'h8C08_0004;

   initial begin
      // Reset and free run
      step(1, 1, 1, 0, 0, 0, LW, 9'h0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, LW, 9'h0);
      // Load-use bubble, then release
      step(0, 0, 0, 1, 0, 0, LW, 9'h1AB);
      step(0, 1, 1, 0, 0, 0, LW, 9'h1AB);
      // Taken branch flush
      step(0, 1, 1, 0, 1, 32'h40, LW, 9'h1AB);
      step(0, 1, 1, 0, 0, 0, LW, 9'h1AB);
      // Branch during stall is ignored, then taken
      step(0, 0, 0, 1, 1, 32'h80, LW, 9'h055);
      step(0, 1, 1, 0, 1, 32'h80, LW, 9'h055);
      step(0, 1, 1, 0, 0, 0, 32'h1234_5678, 9'h055);
      // Stall timeout, protocol error, reset mid-stall
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, LW, 9'h0F0);
      step(0, 1, 0, 0, 0, 0, LW, 9'h0F0);
      step(0, 0, 0, 1, 0, 0, LW, 9'h0F0);
      step(1, 0, 0, 1, 1, 32'h44, LW, 9'h0F0);
      step(0, 1, 1, 0, 0, 0, LW, 9'h0F0);
      // PC wrap
      step(0, 1, 1, 0, 1, 32'hFFFF_FFFC, LW, 9'h001);
      step(0, 1, 1, 0, 0, 0, LW, 9'h001);
      step(0, 1, 1, 0, 0, 0, LW, 9'h001);
      // Stall counter saturation
      for (int i = 0; i < CNT_MAX + 4; i++) step(0, 0, 0, 1, 0, 0, LW, 9'h0, 1'b0);
      step(0, 0, 0, 1, 0, 0, LW, 9'h0);
      step(0, 1, 1, 0, 0, 0, LW, 9'h1FF);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit pcw, ifw, hm, bt, r;
         pcw = ($urandom_range(0, 3) != 0);
         ifw = ($urandom_range(0, 15) == 0) ? !pcw : pcw;
         hm  = ($urandom_range(0, 15) == 0) ? pcw : !pcw;
         bt  = ($urandom_range(0, 4) == 0);
         r   = ($urandom_range(0, 63) == 0);
         step(r, pcw, ifw, hm, bt, $urandom & 32'hFFFF_FFFC, $urandom, 9'($urandom));
      end
      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
